// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// The bit period is max(div,1) clock cycles and is latched when each frame starts.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV_W = 16
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic [DIV_W-1:0]       div,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic                   ser_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] period_q, period_d, timer_q, timer_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             tx_q, tx_d;
    logic             push, pop, bit_end, not_empty;
    logic [DIV_W-1:0] div_eff;

    assign not_empty = level_q != '0;
    assign wr_ready  = level_q != LW'(DEPTH);
    assign push      = wr_valid && wr_ready;
    assign bit_end   = timer_q == '0;
    assign div_eff   = (div == '0) ? DIV_W'(1) : div;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                pop  = not_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    timer_d = period_q - DIV_W'(1);
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = period_q - DIV_W'(1);
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 4'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d     = shift_q[1];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    pop     = not_empty;
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop from IDLE or at the end of STOP both launch the next frame directly.
        if (pop) begin
            state_d  = START;
            shift_d  = mem_q[rptr_q];
            period_d = div_eff;
            timer_d  = div_eff - DIV_W'(1);
            bitcnt_d = '0;
            tx_d     = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            shift_q  <= '0;
            period_q <= '0;
            timer_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    assign ser_tx = tx_q;
    assign busy   = (state_q != IDLE) || not_empty;
    assign level  = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a frame-level line model is compared every cycle,
// and hand-computed line samples and decoded bytes pin the model.
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIV_W = 16;

    logic                   clock = 1'b0;
    logic                   resetb;
    logic [DIV_W-1:0]       div;
    logic                   wr_valid;
    logic [7:0]             wr_data;
    logic                   wr_ready;
    logic                   ser_tx;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;

    int checks   = 0;
    int failures = 0;

    // Model: pending bytes, the frame on the line, and a log of frames launched.
    logic [7:0] m_fifo[$];
    logic [7:0] m_log[$];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    int         m_period  = 1;
    logic [7:0] m_byte    = '0;

    logic [9:0]  bits10;
    logic [29:0] seq;
    logic [7:0]  exp3 [3];

    uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clock   (clock),
        .resetb  (resetb),
        .div     (div),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .ser_tx  (ser_tx),
        .busy    (busy),
        .level   (level)
    );

    always #5 clock = ~clock;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int sz;
        bit push;
        if (!resetb) begin
            m_fifo.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
        end else begin
            sz   = m_fifo.size();
            push = wr_valid && (sz < int'(DEPTH));
            if (m_active) begin
                if (m_elapsed == 10 * m_period - 1) m_active = 1'b0;
                else m_elapsed++;
            end
            if (!m_active && sz > 0) begin
                m_byte    = m_fifo.pop_front();
                m_period  = (div == '0) ? 1 : int'(div);
                m_elapsed = 0;
                m_active  = 1'b1;
                m_log.push_back(m_byte);
            end
            if (push) m_fifo.push_back(wr_data);
        end
    endtask

    task automatic compare();
        logic exp_tx;
        int   sz;
        sz     = m_fifo.size();
        exp_tx = m_active ? frame_bit(m_byte, m_elapsed / m_period) : 1'b1;
        chk("ser_tx",   32'(ser_tx),   32'(exp_tx));
        chk("busy",     32'(busy),     32'(m_active || sz > 0));
        chk("level",    32'(level),    32'(sz));
        chk("wr_ready", 32'(wr_ready), 32'(sz < int'(DEPTH)));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_tx"},    32'(ser_tx),   32'd1);
        chk({name, "_busy"},  32'(busy),     32'd0);
        chk({name, "_level"}, 32'(level),    32'd0);
        chk({name, "_ready"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        resetb   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        div      = 16'd4;

        // Reset hold and release
        repeat (5) begin
            step();
            chk_idle("rst_hold");
        end
        resetb = 1'b1;
        repeat (3) begin
            step();
            chk_idle("rst_after");
        end

        // Single byte 0xA5, div=4
        m_log.delete();
        div      = 16'd4;
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("t1_level_E", 32'(level), 32'd1);
        chk("t1_idle_E",  32'(ser_tx), 32'd1);
        step();
        chk("t1_start", 32'(ser_tx), 32'd0);
        chk("t1_busy",  32'(busy),   32'd1);
        bits10[0] = ser_tx;
        for (int k = 1; k < 10; k++) begin
            steps(4);
            bits10[k] = ser_tx;
        end
        chk("t1_frame", 32'(bits10), 32'h34A);
        steps(3);
        chk("t1_busy_last", 32'(busy), 32'd1);
        step();
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_log_n", 32'(m_log.size()), 32'd1);
        chk("t1_log_0", 32'(m_log[0]), 32'hA5);

        // Back-to-back 0x01,0x02,0x03, div=2
        m_log.delete();
        div      = 16'd2;
        wr_data  = 8'h01;
        wr_valid = 1'b1;
        step();
        chk("t2_level_1", 32'(level), 32'd1);
        wr_data = 8'h02;
        step();
        chk("t2_start", 32'(ser_tx), 32'd0);
        seq[0]  = ser_tx;
        wr_data = 8'h03;
        step();
        chk("t2_level_peak", 32'(level), 32'd2);
        wr_valid = 1'b0;
        step();
        seq[1] = ser_tx;
        for (int k = 2; k < 30; k++) begin
            steps(2);
            seq[k] = ser_tx;
        end
        step();
        chk("t2_busy_last", 32'(busy), 32'd1);
        step();
        chk("t2_busy_fall", 32'(busy),  32'd0);
        chk("t2_level_end", 32'(level), 32'd0);
        exp3[0] = 8'h01;
        exp3[1] = 8'h02;
        exp3[2] = 8'h03;
        for (int f = 0; f < 3; f++) begin
            chk("t2_rx_start", 32'(seq[10*f]),       32'd0);
            chk("t2_rx_stop",  32'(seq[10*f+9]),     32'd1);
            chk("t2_rx_byte",  32'(seq[10*f+1 +: 8]), 32'(exp3[f]));
        end
        chk("t2_log_n", 32'(m_log.size()), 32'd3);

        // Full FIFO, div=100, six writes with wr_valid held
        m_log.delete();
        div      = 16'd100;
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(16 + i);
            step();
            if (i >= 4) begin
                chk("t3_full_ready", 32'(wr_ready), 32'd0);
                chk("t3_full_level", 32'(level),    32'd4);
            end
        end
        wr_valid = 1'b0;
        steps(5000);
        chk("t3_drained", 32'(busy), 32'd0);
        chk("t3_log_n", 32'(m_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("t3_log_byte", 32'(m_log[i]), 32'(16 + i));

        // div=0 gives one-cycle bits, 0x55
        m_log.delete();
        div      = 16'd0;
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        bits10[0] = ser_tx;
        for (int k = 1; k < 10; k++) begin
            step();
            bits10[k] = ser_tx;
        end
        chk("t4_frame", 32'(bits10), 32'h2AA);
        step();
        chk("t4_busy_fall", 32'(busy), 32'd0);

        // div changed 3 -> 7 during the first of two frames
        m_log.delete();
        div      = 16'd3;
        wr_data  = 8'h0F;
        wr_valid = 1'b1;
        step();
        wr_data = 8'hF0;
        step();
        wr_valid = 1'b0;
        chk("t5_start", 32'(ser_tx), 32'd0);
        for (int n = 2; n <= 101; n++) begin
            step();
            if (n == 2) div = 16'd7;
            case (n)
                3:   chk("t5_f1_start_end", 32'(ser_tx), 32'd0);
                4:   chk("t5_f1_b0",        32'(ser_tx), 32'd1);
                15:  chk("t5_f1_b3",        32'(ser_tx), 32'd1);
                16:  chk("t5_f1_b4",        32'(ser_tx), 32'd0);
                65:  chk("t5_f2_b3",        32'(ser_tx), 32'd0);
                66:  chk("t5_f2_b4",        32'(ser_tx), 32'd1);
                100: chk("t5_busy_last",    32'(busy),   32'd1);
                101: chk("t5_busy_fall",    32'(busy),   32'd0);
                default: ;
            endcase
        end
        chk("t5_log_n", 32'(m_log.size()), 32'd2);
        chk("t5_log_1", 32'(m_log[1]), 32'hF0);

        // Reset during DATA bit 3 of 0xFF with 0x00 queued, div=8
        m_log.delete();
        div      = 16'd8;
        wr_data  = 8'hFF;
        wr_valid = 1'b1;
        step();
        wr_data = 8'h00;
        step();
        wr_valid = 1'b0;
        steps(33);
        chk("t6_pre_tx",    32'(ser_tx), 32'd1);
        chk("t6_pre_level", 32'(level),  32'd1);
        resetb = 1'b0;
        step();
        chk("t6_rst_tx",    32'(ser_tx), 32'd1);
        chk("t6_rst_level", 32'(level),  32'd0);
        chk("t6_rst_busy",  32'(busy),   32'd0);
        resetb = 1'b1;
        steps(200);
        chk_idle("t6_after");
        chk("t6_log_n", 32'(m_log.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter (8N1, LSB first) with a small input FIFO.
- Placed in the user project area to stream TDC results and console text off-chip on a single mprj_io pin.
- It is the transmit end of the serial link whose receive end is the testbench UART (ser_rx) on mprj_io[6].
- Bit period comes from a runtime divisor so firmware can match the bench baud rate.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clock  input  1  system clock (40 MHz in the standard bench).
- resetb  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- div  input  DIV_W  clock cycles per serial bit; value 0 is treated as 1.
- wr_valid  input  1  producer has a byte on wr_data.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO can accept a byte; equals not-full.
- ser_tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetb low at a rising edge):
  - ser_tx=1, busy=0, level=0, wr_ready=1.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Reset applied mid-frame aborts the frame; ser_tx is high after that edge; queued bytes are discarded.
- Write handshake:
  - A byte is accepted on a rising edge where wr_valid and wr_ready are both high.
  - wr_ready is computed from the registered level only. When full it stays low even if a pop happens in the same cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- FIFO pointers wrap modulo DEPTH. level counts 0..DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: ser_tx=1. If level>0, pop the head byte into a shift register, latch the bit period max(div,1) into a period register, load the bit counter, and go to START.
  - START: ser_tx=0 for one bit period.
  - DATA: ser_tx = shift[0]. Shift right after each bit period; 8 bits total.
  - STOP: ser_tx=1 for one bit period. Then go to IDLE; if level>0, pop in that same cycle so frames go back-to-back with no extra idle.
- Bit timer:
  - Down-counter loaded with period-1 on state or bit entry.
  - The bit ends on the cycle the counter reads 0.
  - Each bit lasts exactly period cycles.
- div is sampled only when a frame starts. Changing it mid-frame does not affect the frame in progress.
- Latency: for a byte accepted at edge E with the FIFO empty and FSM in IDLE, ser_tx falls after edge E+1. The full frame then lasts 10*period cycles.
- busy = (state != IDLE) or (level != 0), registered-equivalent.
- ser_tx is driven from a flop, so the output is glitch-free.
- Arithmetic: the bit counter is 4 bits and the timer is DIV_W bits. No overflow is possible because the timer only counts down from period-1.

Test Plan:
- Reset check: hold resetb low for 5 cycles, wr_valid=0 -> ser_tx=1, busy=0, level=0, wr_ready=1 throughout and after release.
- Single byte: div=4, write 0xA5 at edge E -> ser_tx low after E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. busy falls 40 cycles after the start bit began.
- Back-to-back: div=2, write 0x01,0x02,0x03 on consecutive cycles -> three contiguous 20-cycle frames with no idle between them. The receiver model decodes 0x01,0x02,0x03 and level goes 1,2,... then down to 0.
- Full FIFO: div=100, write DEPTH+2 bytes with wr_valid held high -> wr_ready drops once level reaches DEPTH. Only accepted bytes appear on ser_tx, in order, with none duplicated or lost.
- Divisor edge cases: div=0 -> 1-cycle bits, 10-cycle frame for 0x55. div changed from 3 to 7 mid-frame -> the current frame keeps 3-cycle bits and the next frame uses 7.
- Reset mid-frame: div=8, write 0xFF then 0x00, assert resetb low during DATA bit 3 -> ser_tx=1 and level=0 after that edge. After release, no residual bytes are transmitted.
